uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receiver core: synchronizes the serial line, frames start/data/parity/stop bits
// at OVERSAMPLE ticks per bit and emits registered one-clock result strobes.
module uart_rx_core #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        uartRxd,
    input  logic [15:0] baudDivisor,
    input  logic        parityEnable,
    input  logic        parityOdd,
    input  logic        fifoFull,
    output logic        fifoWriteEnable,
    output logic [7:0]  fifoWriteData,
    output logic        frameError,
    output logic        parityError,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [4:0] SampLast = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] SampHalf = 5'(OVERSAMPLE / 2 - 1);

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] tick_cnt_q;
    logic [4:0]  samp_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_flag_q;
    logic        we_q, fe_q, pe_q, ov_q;
    logic [7:0]  wdata_q;

    logic        tick, sample;
    logic [4:0]  samp_target;
    logic        we_d, fe_d, pe_d, ov_d;
    logic        par_bad;

    always_comb begin
        tick        = (state_q != StIdle) && (tick_cnt_q == 16'd0);
        samp_target = (state_q == StStart) ? SampHalf : SampLast;
        sample      = tick && (samp_cnt_q == samp_target);
        par_bad     = rx_s_q != ((^shift_q) ^ parityOdd);
        state_d     = state_q;
        we_d        = 1'b0;
        fe_d        = 1'b0;
        pe_d        = 1'b0;
        ov_d        = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (sample) state_d = rx_s_q ? StIdle : StData;
            end
            StData: begin
                if (sample && bit_cnt_q == 3'd7) state_d = parityEnable ? StParity : StStop;
            end
            StParity: begin
                if (sample) state_d = StStop;
            end
            StStop: begin
                if (sample) begin
                    state_d = StIdle;
                    // Error priority: framing, then parity, then overrun
                    if (!rx_s_q)        fe_d = 1'b1;
                    else if (par_flag_q) pe_d = 1'b1;
                    else if (fifoFull)   ov_d = 1'b1;
                    else                 we_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= 16'd0;
            samp_cnt_q <= 5'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_flag_q <= 1'b0;
            we_q       <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
            wdata_q    <= 8'h00;
        end else begin
            rx_meta_q <= uartRxd;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;

            if (state_q == StIdle) begin
                tick_cnt_q <= (state_d == StStart) ? baudDivisor : 16'd0;
            end else if (tick) begin
                tick_cnt_q <= baudDivisor;
            end else begin
                tick_cnt_q <= tick_cnt_q - 16'd1;
            end

            if (state_d != state_q || sample) begin
                samp_cnt_q <= 5'd0;
            end else if (tick) begin
                samp_cnt_q <= samp_cnt_q + 5'd1;
            end

            if (state_q != StData) begin
                bit_cnt_q <= 3'd0;
            end else if (sample) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {rx_s_q, shift_q[7:1]};
            end

            if (state_q == StStart) begin
                par_flag_q <= 1'b0;
            end else if (state_q == StParity && sample) begin
                par_flag_q <= par_bad;
            end

            we_q <= we_d;
            fe_q <= fe_d;
            pe_q <= pe_d;
            ov_q <= ov_d;
            if (we_d) wdata_q <= shift_q;
        end
    end

    assign fifoWriteEnable = we_q;
    assign fifoWriteData   = wdata_q;
    assign frameError      = fe_q;
    assign parityError     = pe_q;
    assign overrun         = ov_q;
    assign busy            = (state_q != StIdle);

endmodule
